// File: rtl/pipe_hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit: the register-number width,
// the forwarding-select codes, and the interlock FSM state encoding.
package pipe_hazard_unit_pkg;

  localparam int unsigned NREG_BITS = 5;

  typedef logic [1:0] fwd_t;

  localparam fwd_t FWD_RF   = 2'b00;  // register file
  localparam fwd_t FWD_EALU = 2'b01;  // EXE ALU result
  localparam fwd_t FWD_MALU = 2'b10;  // MEM ALU result
  localparam fwd_t FWD_MMO  = 2'b11;  // MEM load data

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// ID-stage hazard interface between the decode stage and pipe_hazard_unit.
//   rs/rt/use_rs/use_rt : ID source registers and whether they are read
//   dwreg/dm2reg/drn    : ID destination write-enable, load flag, register
//   wpcir               : 1 = advance, 0 = hold PC and IF/ID, bubble ID/EXE
//   fwda/fwdb           : forwarding selects for operand A/B
// master = decode side (drives ID fields), slave = hazard unit.
interface pipe_hazard_unit_if #(
  parameter int unsigned NREG_BITS = pipe_hazard_unit_pkg::NREG_BITS
);
  logic [NREG_BITS-1:0] rs;
  logic [NREG_BITS-1:0] rt;
  logic                 use_rs;
  logic                 use_rt;
  logic                 dwreg;
  logic                 dm2reg;
  logic [NREG_BITS-1:0] drn;
  logic                 wpcir;
  logic [1:0]           fwda;
  logic [1:0]           fwdb;

  modport master (
    output rs, rt, use_rs, use_rt, dwreg, dm2reg, drn,
    input  wpcir, fwda, fwdb
  );

  modport slave (
    input  rs, rt, use_rs, use_rt, dwreg, dm2reg, drn,
    output wpcir, fwda, fwdb
  );
endinterface

// File: rtl/pipe_hazard_unit_fwd_sel.sv
// fwd_sel: forwarding select for one ID source operand.
//   i_src   : source register number      i_use : operand is read
//   i_ewreg/i_em2reg/i_ern : EXE shadow   i_mwreg/i_mm2reg/i_mrn : MEM shadow
//   o_sel   : FWD_RF / FWD_EALU / FWD_MALU / FWD_MMO
// EXE wins over MEM; a load in EXE cannot forward (the interlock covers it);
// register 0 never forwards.
module fwd_sel
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned NREG_BITS = pipe_hazard_unit_pkg::NREG_BITS
) (
  input  logic [NREG_BITS-1:0] i_src,
  input  logic                 i_use,
  input  logic                 i_ewreg,
  input  logic                 i_em2reg,
  input  logic [NREG_BITS-1:0] i_ern,
  input  logic                 i_mwreg,
  input  logic                 i_mm2reg,
  input  logic [NREG_BITS-1:0] i_mrn,
  output logic [1:0]           o_sel
);

  logic w_ehit;
  logic w_mhit;

  always_comb begin
    w_ehit = i_use & i_ewreg & ~i_em2reg & (i_ern != '0) & (i_ern == i_src);
    w_mhit = i_use & i_mwreg & (i_mrn != '0) & (i_mrn == i_src);
  end

  always_comb begin
    o_sel = FWD_RF;
    if (w_ehit) begin
      o_sel = FWD_EALU;
    end else if (w_mhit) begin
      o_sel = i_mm2reg ? FWD_MMO : FWD_MALU;
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: load-use interlock and operand-forwarding controller.
// Ports:
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   id     : pipe_hazard_unit_if.slave (ID fields in, wpcir/fwda/fwdb out)
//   stall_cnt : 32-bit stall-cycle count, present only with PIPE_STALL_CNT_EN
// Keeps a shadow of the EXE/MEM destination info so it sees the same
// bubbles as the datapath.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned NREG_BITS = pipe_hazard_unit_pkg::NREG_BITS
) (
  input  logic              clock,
  input  logic              resetn,
  pipe_hazard_unit_if.slave id
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_ewreg;
  logic                 r_em2reg;
  logic [NREG_BITS-1:0] r_ern;
  logic                 r_mwreg;
  logic                 r_mm2reg;
  logic [NREG_BITS-1:0] r_mrn;

  logic                 w_ld_hit;
  logic                 w_wpcir;
  logic [1:0]           w_fwda;
  logic [1:0]           w_fwdb;

  // Load in EXE whose destination is read by the ID instruction.
  always_comb begin
    w_ld_hit = r_ewreg & r_em2reg & (r_ern != '0) &
               ((id.use_rs & (r_ern == id.rs)) | (id.use_rt & (r_ern == id.rt)));
  end

  // FSM: state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_ld_hit) w_state_nxt = ST_STALL;
      ST_STALL: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // FSM: outputs. After the stall cycle the load sits in MEM and forwards.
  always_comb begin
    w_wpcir = 1'b1;
    if (r_state == ST_RUN) begin
      w_wpcir = ~w_ld_hit;
    end
  end

  // Shadow EXE/MEM destination info; a stall injects an all-zero bubble.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ewreg  <= 1'b0;
      r_em2reg <= 1'b0;
      r_ern    <= '0;
      r_mwreg  <= 1'b0;
      r_mm2reg <= 1'b0;
      r_mrn    <= '0;
    end else begin
      r_mwreg  <= r_ewreg;
      r_mm2reg <= r_em2reg;
      r_mrn    <= r_ern;
      if (w_wpcir) begin
        r_ewreg  <= id.dwreg;
        r_em2reg <= id.dm2reg;
        r_ern    <= id.drn;
      end else begin
        r_ewreg  <= 1'b0;
        r_em2reg <= 1'b0;
        r_ern    <= '0;
      end
    end
  end

  fwd_sel #(.NREG_BITS(NREG_BITS)) u_fwd_a (
    .i_src    (id.rs),
    .i_use    (id.use_rs),
    .i_ewreg  (r_ewreg),
    .i_em2reg (r_em2reg),
    .i_ern    (r_ern),
    .i_mwreg  (r_mwreg),
    .i_mm2reg (r_mm2reg),
    .i_mrn    (r_mrn),
    .o_sel    (w_fwda)
  );

  fwd_sel #(.NREG_BITS(NREG_BITS)) u_fwd_b (
    .i_src    (id.rt),
    .i_use    (id.use_rt),
    .i_ewreg  (r_ewreg),
    .i_em2reg (r_em2reg),
    .i_ern    (r_ern),
    .i_mwreg  (r_mwreg),
    .i_mm2reg (r_mm2reg),
    .i_mrn    (r_mrn),
    .o_sel    (w_fwdb)
  );

  assign id.wpcir = w_wpcir;
  assign id.fwda  = w_fwda;
  assign id.fwdb  = w_fwdb;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (!w_wpcir) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: stimulus pushes expected outputs
// computed from a history-of-instructions model; a monitor pops and compares.
module tb_pipe_hazard_unit;

  logic clock;
  logic resetn;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  pipe_hazard_unit_if u_if ();

  pipe_hazard_unit #(.NREG_BITS(5)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .id        (u_if)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       w;
    logic       m;
    logic [4:0] rn;
  } ins_t;

  typedef struct {
    logic        wpcir;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t  sb[$];
  ins_t  hist[$];        // hist[0] = instruction now in EXE, hist[1] = in MEM
  int    m_cnt;
  int    n_checks;
  int    n_err;
  event  sample_ev;

  function automatic ins_t slot(input int i);
    if (hist.size() > i) return hist[i];
    return '0;
  endfunction

  // Where the value of register r comes from, judged from what is in flight.
  function automatic logic [1:0] fwd_of(input logic use_r, input logic [4:0] r);
    ins_t e = slot(0);
    ins_t m = slot(1);
    if (!use_r || r == 5'd0) return 2'd0;
    if (e.w && !e.m && e.rn == r) return 2'd1;
    if (m.w && m.rn == r) return m.m ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock or sample_ev);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, " wpcir"}, 32'(u_if.wpcir), 32'(e.wpcir));
        chk({e.tag, " fwda"},  32'(u_if.fwda),  32'(e.fa));
        chk({e.tag, " fwdb"},  32'(u_if.fwdb),  32'(e.fb));
`ifdef PIPE_STALL_CNT_EN
        chk({e.tag, " stall_cnt"}, stall_cnt, e.cnt);
`endif
      end
    end
  end

  // One ID cycle: drive, predict, then account for the coming clock edge.
  task automatic step(input string tag, input logic [4:0] a, input logic [4:0] b,
                      input logic ua, input logic ub, input logic dw, input logic dm,
                      input logic [4:0] dn, output logic stalled);
    exp_t e;
    ins_t ex;
    logic hit;
    @(posedge clock);
    #1;
    u_if.rs = a; u_if.rt = b; u_if.use_rs = ua; u_if.use_rt = ub;
    u_if.dwreg = dw; u_if.dm2reg = dm; u_if.drn = dn;
    ex  = slot(0);
    hit = ex.w && ex.m && ex.rn != 5'd0 &&
          ((ua && ex.rn == a) || (ub && ex.rn == b));
    e.wpcir = !hit;
    e.fa    = fwd_of(ua, a);
    e.fb    = fwd_of(ub, b);
    e.cnt   = 32'(m_cnt);
    e.tag   = tag;
    sb.push_back(e);
    hist.push_front(hit ? ins_t'('0) : ins_t'({dw, dm, dn}));
    if (hist.size() > 2) void'(hist.pop_back());
    if (hit) m_cnt++;
    stalled = hit;
  endtask

  // Issue an instruction, re-presenting it while the interlock holds it.
  task automatic issue(input string tag, input logic [4:0] a, input logic [4:0] b,
                       input logic ua, input logic ub, input logic dw, input logic dm,
                       input logic [4:0] dn);
    logic st;
    int   tries = 0;
    do begin
      step(tag, a, b, ua, ub, dw, dm, dn, st);
      tries++;
    end while (st && tries < 4);
  endtask

  task automatic idle_inputs();
    u_if.rs = '0; u_if.rt = '0; u_if.use_rs = 1'b0; u_if.use_rt = 1'b0;
    u_if.dwreg = 1'b0; u_if.dm2reg = 1'b0; u_if.drn = '0;
  endtask

  task automatic push_reset_exp(input string tag);
    exp_t e;
    e.wpcir = 1'b1; e.fa = 2'd0; e.fb = 2'd0; e.cnt = 32'd0; e.tag = tag;
    sb.push_back(e);
  endtask

  initial begin
    logic st;
    int   guard;
    n_checks = 0; n_err = 0; m_cnt = 0;
    resetn = 1'b0;
    idle_inputs();
    #2;
    push_reset_exp("reset");
    -> sample_ev;
    @(negedge clock);
    resetn = 1'b1;

    // ALU-to-ALU: EXE then MEM forward
    issue("alu_w3",  5'd0, 5'd0, 0, 0, 1, 0, 5'd3);
    issue("alu_ex",  5'd3, 5'd0, 1, 0, 0, 0, 5'd0);
    issue("alu_mem", 5'd3, 5'd0, 1, 0, 0, 0, 5'd0);

    // Load-use on rt, then MEM load data forward
    issue("ld_w5",   5'd0, 5'd0, 0, 0, 1, 1, 5'd5);
    issue("ld_use",  5'd0, 5'd5, 0, 1, 0, 0, 5'd0);

    // Register 0 never forwards
    issue("r0_w",    5'd0, 5'd0, 0, 0, 1, 0, 5'd0);
    issue("r0_rd",   5'd0, 5'd0, 1, 1, 0, 0, 5'd0);

    // EXE beats MEM
    issue("pri_m",   5'd0, 5'd0, 0, 0, 1, 0, 5'd7);
    issue("pri_e",   5'd0, 5'd0, 0, 0, 1, 0, 5'd7);
    issue("pri_rd",  5'd7, 5'd0, 1, 0, 0, 0, 5'd0);

    // Unused operand suppresses stall and forwarding
    issue("nu_ld9",  5'd0, 5'd0, 0, 0, 1, 1, 5'd9);
    issue("nu_rd",   5'd0, 5'd9, 0, 0, 0, 0, 5'd0);

    // Back-to-back load-use: two separate stalls
    issue("bb_ld5",  5'd0, 5'd0, 0, 0, 1, 1, 5'd5);
    issue("bb_ld6",  5'd5, 5'd0, 1, 0, 1, 1, 5'd6);
    issue("bb_use",  5'd6, 5'd0, 1, 0, 0, 0, 5'd0);

    // Reset in the middle of a stall
    issue("rs_ld",   5'd0, 5'd0, 0, 0, 1, 1, 5'd5);
    step("rs_stall", 5'd0, 5'd5, 0, 1, 0, 0, 5'd0, st);
    @(negedge clock);
    #2;
    resetn = 1'b0;
    idle_inputs();
    hist.delete();
    m_cnt = 0;
    #1;
    push_reset_exp("rst_mid");
    -> sample_ev;
    @(posedge clock);
    #2;
    resetn = 1'b1;
    issue("post_ld", 5'd0, 5'd0, 0, 0, 1, 1, 5'd4);
    issue("post_use", 5'd4, 5'd4, 1, 1, 0, 0, 5'd0);

    // Randomized instruction stream over a small register window
    for (int i = 0; i < 600; i++) begin
      issue("rand",
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 4),
            5'($urandom_range(0, 7)));
    end

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clock);
      guard++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
